// File: rtl/arb_m2_if.sv
// Bundle of the two master request/response ports and the downstream slave port of arb_m2.
// The arbiter connects through the slave modport; the master modport is the environment view.
interface arb_m2_if;
  logic        m0_req;
  logic        m0_we;
  logic [31:0] m0_addr;
  logic [3:0]  m0_be;
  logic [31:0] m0_wdata;
  logic        m0_ack;
  logic        m0_resp;
  logic [31:0] m0_rdata;

  logic        m1_req;
  logic        m1_we;
  logic [31:0] m1_addr;
  logic [3:0]  m1_be;
  logic [31:0] m1_wdata;
  logic        m1_ack;
  logic        m1_resp;
  logic [31:0] m1_rdata;

  logic        s_req;
  logic        s_we;
  logic [31:0] s_addr;
  logic [3:0]  s_be;
  logic [31:0] s_wdata;
  logic        s_ack;
  logic        s_resp;
  logic [31:0] s_rdata;

  modport slave (
    input  m0_req, m0_we, m0_addr, m0_be, m0_wdata,
    output m0_ack, m0_resp, m0_rdata,
    input  m1_req, m1_we, m1_addr, m1_be, m1_wdata,
    output m1_ack, m1_resp, m1_rdata,
    output s_req, s_we, s_addr, s_be, s_wdata,
    input  s_ack, s_resp, s_rdata
  );

  modport master (
    output m0_req, m0_we, m0_addr, m0_be, m0_wdata,
    input  m0_ack, m0_resp, m0_rdata,
    output m1_req, m1_we, m1_addr, m1_be, m1_wdata,
    input  m1_ack, m1_resp, m1_rdata,
    input  s_req, s_we, s_addr, s_be, s_wdata,
    output s_ack, s_resp, s_rdata
  );
endinterface

// File: rtl/arb_m2.sv
// Two-master to one-slave request arbiter with sticky grant and an owner FIFO for read responses.
// Define ARB_M2_RR_EN for round-robin arbitration; otherwise m0 has fixed priority.
module arb_m2 #(
  parameter int OUTSTANDING_DEPTH = 4
) (
  input  logic     clk_i,
  input  logic     rst_i,
  arb_m2_if.slave  bus
);
  localparam int PW = $clog2(OUTSTANDING_DEPTH);
  localparam int CW = PW + 1;

  logic [CW-1:0]                count_q, count_d;
  logic [PW-1:0]                rd_ptr_q, rd_ptr_d;
  logic [PW-1:0]                wr_ptr_q, wr_ptr_d;
  logic [OUTSTANDING_DEPTH-1:0] owner_q, owner_d;
  logic                         lock_q, lock_d;
  logic                         lock_idx_q, lock_idx_d;
`ifdef ARB_M2_RR_EN
  logic                         prio_q, prio_d;
`endif

  logic full, elig0, elig1, gnt_vld, gnt_idx, sel_we, push, pop, head, busy;

  always_comb begin
    full  = (count_q == CW'(OUTSTANDING_DEPTH));
    elig0 = bus.m0_req & (bus.m0_we | ~full);
    elig1 = bus.m1_req & (bus.m1_we | ~full);
    if (lock_q) begin
      // A stalled request keeps the channel until the slave accepts it.
      gnt_idx = lock_idx_q;
      gnt_vld = lock_idx_q ? elig1 : elig0;
    end else begin
`ifdef ARB_M2_RR_EN
      gnt_idx = (elig0 & elig1) ? prio_q : elig1;
`else
      gnt_idx = ~elig0;
`endif
      gnt_vld = elig0 | elig1;
    end
    gnt_vld = gnt_vld & ~rst_i;
    sel_we  = gnt_idx ? bus.m1_we : bus.m0_we;
  end

  always_comb begin
    bus.s_req   = gnt_vld;
    bus.s_we    = gnt_vld & sel_we;
    bus.s_addr  = gnt_vld ? (gnt_idx ? bus.m1_addr  : bus.m0_addr)  : '0;
    bus.s_be    = gnt_vld ? (gnt_idx ? bus.m1_be    : bus.m0_be)    : '0;
    bus.s_wdata = gnt_vld ? (gnt_idx ? bus.m1_wdata : bus.m0_wdata) : '0;
    bus.m0_ack  = gnt_vld & ~gnt_idx & bus.s_ack;
    bus.m1_ack  = gnt_vld &  gnt_idx & bus.s_ack;
  end

  always_comb begin
    busy         = ~rst_i & (count_q != '0);
    head         = owner_q[rd_ptr_q];
    bus.m0_resp  = busy & ~head & bus.s_resp;
    bus.m1_resp  = busy &  head & bus.s_resp;
    bus.m0_rdata = (busy & ~head) ? bus.s_rdata : '0;
    bus.m1_rdata = (busy &  head) ? bus.s_rdata : '0;
  end

  always_comb begin
    push     = gnt_vld & bus.s_ack & ~sel_we;
    pop      = busy & bus.s_resp;
    owner_d  = owner_q;
    if (push) owner_d[wr_ptr_q] = gnt_idx;
    wr_ptr_d = wr_ptr_q + PW'(push);
    rd_ptr_d = rd_ptr_q + PW'(pop);
    count_d  = count_q + CW'(push) - CW'(pop);

    lock_d     = lock_q;
    lock_idx_d = lock_idx_q;
    if (bus.s_ack) begin
      lock_d = 1'b0;
    end else if (gnt_vld) begin
      lock_d     = 1'b1;
      lock_idx_d = gnt_idx;
    end
`ifdef ARB_M2_RR_EN
    prio_d = prio_q;
    if (gnt_vld & bus.s_ack) prio_d = ~gnt_idx;
`endif
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      count_q    <= '0;
      rd_ptr_q   <= '0;
      wr_ptr_q   <= '0;
      owner_q    <= '0;
      lock_q     <= 1'b0;
      lock_idx_q <= 1'b0;
`ifdef ARB_M2_RR_EN
      prio_q     <= 1'b0;
`endif
    end else begin
      count_q    <= count_d;
      rd_ptr_q   <= rd_ptr_d;
      wr_ptr_q   <= wr_ptr_d;
      owner_q    <= owner_d;
      lock_q     <= lock_d;
      lock_idx_q <= lock_idx_d;
`ifdef ARB_M2_RR_EN
      prio_q     <= prio_d;
`endif
    end
  end
endmodule

// File: tb/tb_arb_m2.sv
// Scoreboard bench for arb_m2: directed stimulus queues expected accepts and responses,
// a negedge monitor pops and compares them whenever the arbiter acks or returns data.
module tb_arb_m2;
  typedef struct {
    logic        idx;
    logic [31:0] val;
  } exp_t;

  logic clk_i = 1'b0;
  logic rst_i = 1'b1;
  int   n_chk = 0;
  int   n_fail = 0;
  exp_t acc_q[$];
  exp_t rsp_q[$];

  arb_m2_if bus ();
  arb_m2 #(.OUTSTANDING_DEPTH(4)) dut (.clk_i(clk_i), .rst_i(rst_i), .bus(bus));

  always #5 clk_i = ~clk_i;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic tick();
    @(posedge clk_i);
    #1;
  endtask

  task automatic settle();
    @(negedge clk_i);
  endtask

  task automatic idle();
    bus.m0_req = 0; bus.m0_we = 0; bus.m0_addr = 0; bus.m0_be = 0; bus.m0_wdata = 0;
    bus.m1_req = 0; bus.m1_we = 0; bus.m1_addr = 0; bus.m1_be = 0; bus.m1_wdata = 0;
    bus.s_ack = 0; bus.s_resp = 0; bus.s_rdata = 0;
  endtask

  task automatic exp_acc(input logic idx, input logic [31:0] addr);
    exp_t e;
    e.idx = idx; e.val = addr;
    acc_q.push_back(e);
  endtask

  task automatic exp_rsp(input logic idx, input logic [31:0] data);
    exp_t e;
    e.idx = idx; e.val = data;
    rsp_q.push_back(e);
  endtask

  task automatic chk_all_zero(input string tag);
    chk({tag, "_s_req"},   {31'd0, bus.s_req}, 0);
    chk({tag, "_s_we"},    {31'd0, bus.s_we}, 0);
    chk({tag, "_s_addr"},  bus.s_addr, 0);
    chk({tag, "_s_be"},    {28'd0, bus.s_be}, 0);
    chk({tag, "_s_wdata"}, bus.s_wdata, 0);
    chk({tag, "_acks"},    {30'd0, bus.m1_ack, bus.m0_ack}, 0);
    chk({tag, "_resps"},   {30'd0, bus.m1_resp, bus.m0_resp}, 0);
    chk({tag, "_m0_rdata"}, bus.m0_rdata, 0);
    chk({tag, "_m1_rdata"}, bus.m1_rdata, 0);
  endtask

  always @(negedge clk_i) begin
    if (!rst_i) begin
      if (bus.m0_ack | bus.m1_ack) begin
        if (acc_q.size() == 0) begin
          chk("unexpected_ack", {30'd0, bus.m1_ack, bus.m0_ack}, 0);
        end else begin
          exp_t e;
          e = acc_q.pop_front();
          chk("ack_both", {31'd0, bus.m0_ack & bus.m1_ack}, 0);
          chk("ack_idx", {31'd0, bus.m1_ack}, {31'd0, e.idx});
          chk("ack_addr", bus.s_addr, e.val);
        end
      end
      if (bus.m0_resp | bus.m1_resp) begin
        if (rsp_q.size() == 0) begin
          chk("unexpected_resp", {30'd0, bus.m1_resp, bus.m0_resp}, 0);
        end else begin
          exp_t e;
          e = rsp_q.pop_front();
          chk("resp_idx", {31'd0, bus.m1_resp}, {31'd0, e.idx});
          chk("resp_data", bus.m1_resp ? bus.m1_rdata : bus.m0_rdata, e.val);
          chk("resp_other_rdata", bus.m1_resp ? bus.m0_rdata : bus.m1_rdata, 0);
        end
      end
    end
  end

  initial begin
    idle();
    rst_i = 1;
    tick(); tick();
    settle();
    chk_all_zero("reset");
    tick();
    rst_i = 0;

    // Contention: both masters issue reads back to back.
    for (int i = 0; i < 4; i++) begin
      bus.m0_req = 1; bus.m0_we = 0; bus.m0_addr = 32'h0000_1000; bus.m0_be = 4'hF;
      bus.m1_req = 1; bus.m1_we = 0; bus.m1_addr = 32'h0000_2000; bus.m1_be = 4'hF;
      bus.s_ack = 1;
`ifdef ARB_M2_RR_EN
      exp_acc(1'(i % 2), (i % 2 == 0) ? 32'h0000_1000 : 32'h0000_2000);
      exp_rsp(1'(i % 2), 32'hA0 + 32'(i));
`else
      exp_acc(1'b0, 32'h0000_1000);
      exp_rsp(1'b0, 32'hA0 + 32'(i));
`endif
      settle();
`ifndef ARB_M2_RR_EN
      chk("fixed_m1_ack", {31'd0, bus.m1_ack}, 0);
`endif
      tick();
    end
    idle();
    for (int i = 0; i < 4; i++) begin
      bus.s_resp = 1; bus.s_rdata = 32'hA0 + 32'(i);
      settle();
      tick();
    end
    idle();

    // Single read with a response two cycles after acceptance.
    bus.m0_req = 1; bus.m0_we = 0; bus.m0_addr = 32'h0000_0100; bus.m0_be = 4'hF; bus.s_ack = 1;
    exp_acc(1'b0, 32'h0000_0100);
    exp_rsp(1'b0, 32'hDEAD_BEEF);
    settle(); tick();
    idle();
    settle(); tick();
    bus.s_resp = 1; bus.s_rdata = 32'hDEAD_BEEF;
    settle();
    chk("single_m1_resp", {31'd0, bus.m1_resp}, 0);
    tick();
    bus.s_rdata = 32'h1234_5678;
    settle();
    chk("empty_resps", {30'd0, bus.m1_resp, bus.m0_resp}, 0);
    chk("empty_m0_rdata", bus.m0_rdata, 0);
    chk("empty_m1_rdata", bus.m1_rdata, 0);
    tick();
    idle();

    // Lock: m1 stalls three cycles, m0 joins in the third.
    bus.m1_req = 1; bus.m1_we = 0; bus.m1_addr = 32'h0000_3000; bus.m1_be = 4'h3;
    for (int i = 0; i < 3; i++) begin
      if (i == 2) begin
        bus.m0_req = 1; bus.m0_we = 0; bus.m0_addr = 32'h0000_4000; bus.m0_be = 4'hF;
      end
      settle();
      chk("lock_s_req", {31'd0, bus.s_req}, 1);
      chk("lock_s_addr", bus.s_addr, 32'h0000_3000);
      chk("lock_m0_ack", {31'd0, bus.m0_ack}, 0);
      tick();
    end
    bus.s_ack = 1;
    exp_acc(1'b1, 32'h0000_3000);
    exp_rsp(1'b1, 32'h11);
    settle();
    chk("lock_release_m0_ack", {31'd0, bus.m0_ack}, 0);
    chk("lock_s_be", {28'd0, bus.s_be}, 32'h3);
    tick();
    bus.m1_req = 0;
    exp_acc(1'b0, 32'h0000_4000);
    exp_rsp(1'b0, 32'h22);
    settle(); tick();
    idle();
    bus.s_resp = 1; bus.s_rdata = 32'h11;
    settle(); tick();
    bus.s_rdata = 32'h22;
    settle(); tick();
    idle();

    // Full FIFO: four reads fill it, a write still passes, the read waits for a pop.
    for (int i = 0; i < 4; i++) begin
      bus.m0_req = 1; bus.m0_we = 0; bus.m0_addr = 32'h0000_0500 + 32'(4 * i); bus.m0_be = 4'hF;
      bus.s_ack = 1;
      exp_acc(1'b0, 32'h0000_0500 + 32'(4 * i));
      exp_rsp(1'b0, 32'h55 + 32'(i));
      settle(); tick();
    end
    bus.m0_addr = 32'h0000_0510;
    bus.m1_req = 1; bus.m1_we = 1; bus.m1_addr = 32'h0000_0600; bus.m1_be = 4'hF;
    bus.m1_wdata = 32'hCAFE_0600;
    exp_acc(1'b1, 32'h0000_0600);
    settle();
    chk("full_m0_ack", {31'd0, bus.m0_ack}, 0);
    chk("full_write_we", {31'd0, bus.s_we}, 1);
    chk("full_write_wdata", bus.s_wdata, 32'hCAFE_0600);
    tick();
    bus.m1_req = 0; bus.m1_we = 0;
    bus.s_resp = 1; bus.s_rdata = 32'h55;
    settle();
    chk("pop_cycle_m0_ack", {31'd0, bus.m0_ack}, 0);
    chk("pop_cycle_s_req", {31'd0, bus.s_req}, 0);
    tick();
    bus.s_resp = 0;
    exp_acc(1'b0, 32'h0000_0510);
    exp_rsp(1'b0, 32'h59);
    settle(); tick();
    idle();
    for (int i = 1; i < 5; i++) begin
      bus.s_resp = 1; bus.s_rdata = 32'h55 + 32'(i);
      settle(); tick();
    end
    idle();

    // Reset with two reads outstanding discards their ownership.
    for (int i = 0; i < 2; i++) begin
      bus.m1_req = 1; bus.m1_we = 0; bus.m1_addr = 32'h0000_0700 + 32'(4 * i); bus.s_ack = 1;
      exp_acc(1'b1, 32'h0000_0700 + 32'(4 * i));
      settle(); tick();
    end
    idle();
    rst_i = 1;
    bus.m0_req = 1; bus.m0_we = 1; bus.m0_addr = 32'h0000_0800; bus.m0_be = 4'hF;
    bus.m0_wdata = 32'h1357_9BDF;
    bus.s_ack = 1; bus.s_resp = 1; bus.s_rdata = 32'hFFFF_FFFF;
    settle();
    chk_all_zero("in_reset");
    tick();
    rst_i = 0;
    idle();
    bus.s_resp = 1; bus.s_rdata = 32'h77;
    settle();
    chk("post_reset_resps", {30'd0, bus.m1_resp, bus.m0_resp}, 0);
    chk("post_reset_m0_rdata", bus.m0_rdata, 0);
    chk("post_reset_m1_rdata", bus.m1_rdata, 0);
    tick();
    idle();
    settle();

    chk("acc_queue_drained", 32'(acc_q.size()), 0);
    chk("rsp_queue_drained", 32'(rsp_q.size()), 0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
